// File: rtl/wb_dest_ctrl.sv
// Writeback-stage controller: computes Y86 destination registers (with cmov
// gating), holds the W pipeline register under stall/bubble control, drives
// the register-file write ports, halts on exception status and counts
// retired instructions. Every output comes straight from a flop.
module wb_dest_ctrl #(
    parameter int         DATA_W = 64,
    parameter int         CNT_W  = 32,
    parameter logic [3:0] RSP_ID = 4'h4,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic              Cnd_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic [2:0]        stat_i,
    output logic [3:0]        dstE_o,
    output logic [3:0]        dstM_o,
    output logic [DATA_W-1:0] valE_o,
    output logic [DATA_W-1:0] valM_o,
    output logic              wE_o,
    output logic              wM_o,
    output logic [2:0]        stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam logic [2:0] STAT_AOK = 3'd1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;

    logic [3:0]         dste_s;
    logic [3:0]         dstm_s;
    logic               we_s;
    logic               wm_s;
    logic               stat_ok_s;
    logic               load_s;
    logic               bubble_s;
    logic               retire_s;

    logic [3:0]         dste_r;
    logic [3:0]         dstm_r;
    logic [DATA_W-1:0]  vale_r;
    logic [DATA_W-1:0]  valm_r;
    logic               we_r;
    logic               wm_r;
    logic [2:0]         stat_r;
    logic               halted_r;
    logic [CNT_W-1:0]   retired_r;

    // Destination register selection from the instruction fields
    always_comb begin
        dste_s = RNONE;
        dstm_s = RNONE;
        case (icode_i)
            4'h2: begin
                // cmovXX only writes when the condition held
                if (Cnd_i) begin
                    dste_s = rB_i;
                end else begin
                    dste_s = RNONE;
                end
            end
            4'h3, 4'h6:               dste_s = rB_i;
            4'h8, 4'h9, 4'hA, 4'hB:   dste_s = RSP_ID;
            default:                  dste_s = RNONE;
        endcase
        case (icode_i)
            4'h5, 4'hB: dstm_s = rA_i;
            default:    dstm_s = RNONE;
        endcase
    end

    // Write enables: exceptions never write, and on popq %rsp the M port wins
    always_comb begin
        stat_ok_s = (stat_i == STAT_AOK);
        if ((dstm_s != RNONE) && stat_ok_s) begin
            wm_s = 1'b1;
        end else begin
            wm_s = 1'b0;
        end
        if ((dste_s != RNONE) && (dste_s != dstm_s) && stat_ok_s) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // RUN/HALT next state plus W-register load and retire decisions
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        bubble_s    = 1'b0;
        retire_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (stall_i) begin
                    state_nxt_s = ST_RUN;
                end else if (bubble_i || !valid_i) begin
                    bubble_s = 1'b1;
                end else begin
                    load_s = 1'b1;
                    if (stat_ok_s) begin
                        retire_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register and its registered halted flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

    // W pipeline register: bubble or load; otherwise hold (stall or HALT)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dste_r <= RNONE;
            dstm_r <= RNONE;
            vale_r <= {DATA_W{1'b0}};
            valm_r <= {DATA_W{1'b0}};
            we_r   <= 1'b0;
            wm_r   <= 1'b0;
            stat_r <= STAT_AOK;
        end else if (bubble_s) begin
            dste_r <= RNONE;
            dstm_r <= RNONE;
            vale_r <= {DATA_W{1'b0}};
            valm_r <= {DATA_W{1'b0}};
            we_r   <= 1'b0;
            wm_r   <= 1'b0;
            stat_r <= STAT_AOK;
        end else if (load_s) begin
            dste_r <= dste_s;
            dstm_r <= dstm_s;
            vale_r <= valE_i;
            valm_r <= valM_i;
            we_r   <= we_s;
            wm_r   <= wm_s;
            stat_r <= stat_i;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign dstE_o    = dste_r;
    assign dstM_o    = dstm_r;
    assign valE_o    = vale_r;
    assign valM_o    = valm_r;
    assign wE_o      = we_r;
    assign wM_o      = wm_r;
    assign stat_o    = stat_r;
    assign halted_o  = halted_r;
    assign retired_o = retired_r;

endmodule

// File: tb/tb_wb_dest_ctrl.sv
// Self-checking bench for wb_dest_ctrl: directed scenarios from the
// instruction-level behaviour plus randomized traffic against a reference
// model of the writeback stage. A second instance with a 4-bit counter
// exercises the retire-counter wrap.
module tb_wb_dest_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, stall_i, bubble_i, Cnd_i;
    logic [3:0]  icode_i, rA_i, rB_i;
    logic [63:0] valE_i, valM_i;
    logic [2:0]  stat_i;

    logic [3:0]  dstE_o, dstM_o;
    logic [63:0] valE_o, valM_o;
    logic        wE_o, wM_o, halted_o;
    logic [2:0]  stat_o;
    logic [31:0] retired_o;

    logic [3:0]  w_dste, w_dstm;
    logic [63:0] w_vale, w_valm;
    logic        w_we, w_wm, w_halted;
    logic [2:0]  w_stat;
    logic [3:0]  w_retired;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    logic [3:0]  m_dste, m_dstm;
    logic [63:0] m_vale, m_valm;
    logic        m_we, m_wm, m_halted;
    logic [2:0]  m_stat;
    logic [31:0] m_ret;

    always #5 clk_i = ~clk_i;

    wb_dest_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .bubble_i(bubble_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .Cnd_i(Cnd_i), .valE_i(valE_i), .valM_i(valM_i), .stat_i(stat_i),
        .dstE_o(dstE_o), .dstM_o(dstM_o), .valE_o(valE_o), .valM_o(valM_o),
        .wE_o(wE_o), .wM_o(wM_o), .stat_o(stat_o), .halted_o(halted_o),
        .retired_o(retired_o)
    );

    wb_dest_ctrl #(.CNT_W(4)) dut_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .bubble_i(bubble_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .Cnd_i(Cnd_i), .valE_i(valE_i), .valM_i(valM_i), .stat_i(stat_i),
        .dstE_o(w_dste), .dstM_o(w_dstm), .valE_o(w_vale), .valM_o(w_valm),
        .wE_o(w_we), .wM_o(w_wm), .stat_o(w_stat), .halted_o(w_halted),
        .retired_o(w_retired)
    );

    task automatic drive(input logic v, input logic st, input logic bu,
                         input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [2:0] s);
        valid_i = v; stall_i = st; bubble_i = bu; icode_i = ic; rA_i = ra;
        rB_i = rb; Cnd_i = c; valE_i = ve; valM_i = vm; stat_i = s;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    function automatic logic [3:0] ref_dste(input logic [3:0] ic, input logic [3:0] rb,
                                            input logic c);
        if (ic == 4'h2) return c ? rb : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return rb;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dstm(input logic [3:0] ic, input logic [3:0] ra);
        return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
    endfunction

    task automatic model_reset();
        m_dste = 4'hF; m_dstm = 4'hF; m_vale = 64'd0; m_valm = 64'd0;
        m_we = 1'b0; m_wm = 1'b0; m_stat = 3'd1; m_halted = 1'b0; m_ret = 32'd0;
    endtask

    // apply one clock edge worth of writeback behaviour to the model
    task automatic model_step();
        logic [3:0] e, m;
        if (m_halted || stall_i) return;
        if (bubble_i || !valid_i) begin
            m_dste = 4'hF; m_dstm = 4'hF; m_vale = 64'd0; m_valm = 64'd0;
            m_we = 1'b0; m_wm = 1'b0; m_stat = 3'd1;
            return;
        end
        e = ref_dste(icode_i, rB_i, Cnd_i);
        m = ref_dstm(icode_i, rA_i);
        m_dste = e; m_dstm = m; m_vale = valE_i; m_valm = valM_i; m_stat = stat_i;
        m_wm = (m != 4'hF) && (stat_i == 3'd1);
        m_we = (e != 4'hF) && (e != m) && (stat_i == 3'd1);
        if (stat_i != 3'd1) m_halted = 1'b1;
        else m_ret = m_ret + 32'd1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd1);
        #1;
        vectors++;
        if ({dstE_o, dstM_o, valE_o, valM_o} !== {4'hF, 4'hF, 64'd0, 64'd0}) begin
            miscompares++;
            $display("FAIL reset_dst_val got %h %h %h %h want f f 0 0", dstE_o, dstM_o, valE_o, valM_o);
        end
        vectors++;
        if ({wE_o, wM_o, stat_o, halted_o, retired_o} !== {1'b0, 1'b0, 3'd1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_ctl got we=%b wm=%b stat=%0d halt=%b ret=%0d want 0 0 1 0 0",
                     wE_o, wM_o, stat_o, halted_o, retired_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_irmovq();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h3, 4'hF, 4'h2, 1'b0, 64'd1, 64'd0, 3'd1);
        tick();
        vectors++;
        if ({dstE_o, wE_o, valE_o, wM_o, retired_o} !== {4'h2, 1'b1, 64'd1, 1'b0, 32'd1}) begin
            miscompares++;
            $display("FAIL irmovq got dstE=%h wE=%b valE=%0d wM=%b ret=%0d want 2 1 1 0 1",
                     dstE_o, wE_o, valE_o, wM_o, retired_o);
        end
    endtask

    task automatic test_cmov();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h2, 4'h6, 4'h0, 1'b1, 64'd4, 64'd0, 3'd1);
        tick();
        vectors++;
        if ({dstE_o, wE_o, retired_o} !== {4'h0, 1'b1, 32'd1}) begin
            miscompares++;
            $display("FAIL cmov_taken got dstE=%h wE=%b ret=%0d want 0 1 1", dstE_o, wE_o, retired_o);
        end
        Cnd_i = 1'b0;
        tick();
        vectors++;
        if ({dstE_o, wE_o, retired_o} !== {4'hF, 1'b0, 32'd2}) begin
            miscompares++;
            $display("FAIL cmov_not_taken got dstE=%h wE=%b ret=%0d want f 0 2", dstE_o, wE_o, retired_o);
        end
    endtask

    task automatic test_pop_mrmov();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'hB, 4'h4, 4'hF, 1'b0, 64'h10, 64'h123, 3'd1);
        tick();
        vectors++;
        if ({dstE_o, dstM_o, wE_o, wM_o, valM_o} !== {4'h4, 4'h4, 1'b0, 1'b1, 64'h123}) begin
            miscompares++;
            $display("FAIL popq_rsp got dstE=%h dstM=%h wE=%b wM=%b valM=%h want 4 4 0 1 123",
                     dstE_o, dstM_o, wE_o, wM_o, valM_o);
        end
        drive(1'b1, 1'b0, 1'b0, 4'h5, 4'h3, 4'h1, 1'b1, 64'h20, 64'h55, 3'd1);
        tick();
        vectors++;
        if ({dstE_o, dstM_o, wE_o, wM_o} !== {4'hF, 4'h3, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mrmovq got dstE=%h dstM=%h wE=%b wM=%b want f 3 0 1",
                     dstE_o, dstM_o, wE_o, wM_o);
        end
    endtask

    task automatic test_stall_bubble();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h6, 4'hF, 4'h3, 1'b0, 64'd3, 64'd0, 3'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 1), 4'h3, 4'h1, 4'(i + 5), 1'b1, 64'(i + 100), 64'd7, 3'd1);
            tick();
            vectors++;
            if ({dstE_o, valE_o, retired_o} !== {4'h3, 64'd3, 32'd1}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got dstE=%h valE=%0d ret=%0d want 3 3 1",
                         i, dstE_o, valE_o, retired_o);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 4'h3, 4'h1, 4'h2, 1'b1, 64'd9, 64'd7, 3'd1);
        tick();
        vectors++;
        if ({wE_o, wM_o, stat_o, dstE_o, retired_o} !== {1'b0, 1'b0, 3'd1, 4'hF, 32'd1}) begin
            miscompares++;
            $display("FAIL bubble got wE=%b wM=%b stat=%0d dstE=%h ret=%0d want 0 0 1 f 1",
                     wE_o, wM_o, stat_o, dstE_o, retired_o);
        end
    endtask

    task automatic test_exception();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h6, 4'hF, 4'h2, 1'b0, 64'd8, 64'd0, 3'd3);
        tick();
        vectors++;
        if ({wE_o, wM_o, stat_o, halted_o, retired_o} !== {1'b0, 1'b0, 3'd3, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL adr_entry got wE=%b wM=%b stat=%0d halt=%b ret=%0d want 0 0 3 1 0",
                     wE_o, wM_o, stat_o, halted_o, retired_o);
        end
        drive(1'b1, 1'b0, 1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'd77, 64'd0, 3'd1);
        tick();
        tick();
        vectors++;
        if ({dstE_o, valE_o, wE_o, stat_o, halted_o, retired_o} !==
            {4'h2, 64'd8, 1'b0, 3'd3, 1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL halt_frozen got dstE=%h valE=%0d wE=%b stat=%0d halt=%b ret=%0d want 2 8 0 3 1 0",
                     dstE_o, valE_o, wE_o, stat_o, halted_o, retired_o);
        end
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({dstE_o, valE_o, stat_o, halted_o, retired_o} !== {4'hF, 64'd0, 3'd1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL async_reset got dstE=%h valE=%0d stat=%0d halt=%b ret=%0d want f 0 1 0 0",
                     dstE_o, valE_o, stat_o, halted_o, retired_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd1);
        for (int i = 0; i < 17; i++) tick();
        vectors++;
        if (w_retired !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap got ret=%0d want 1", w_retired);
        end
        vectors++;
        if (retired_o !== 32'd17) begin
            miscompares++;
            $display("FAIL count17 got ret=%0d want 17", retired_o);
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset();
                model_reset();
            end
            s = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, s);
            @(posedge clk_i);
            model_step();
            #1;
            vectors++;
            if ({dstE_o, dstM_o, valE_o, valM_o, wE_o, wM_o, stat_o, halted_o, retired_o} !==
                {m_dste, m_dstm, m_vale, m_valm, m_we, m_wm, m_stat, m_halted, m_ret}) begin
                miscompares++;
                $display("FAIL random[%0d] got dE=%h dM=%h vE=%h vM=%h wE=%b wM=%b st=%0d h=%b r=%0d want dE=%h dM=%h vE=%h vM=%h wE=%b wM=%b st=%0d h=%b r=%0d",
                         i, dstE_o, dstM_o, valE_o, valM_o, wE_o, wM_o, stat_o, halted_o, retired_o,
                         m_dste, m_dstm, m_vale, m_valm, m_we, m_wm, m_stat, m_halted, m_ret);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd1);
        test_reset();
        test_irmovq();
        test_cmov();
        test_pop_mrmov();
        test_stall_bubble();
        test_exception();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
